game_over_ctrl: RTL

Game-over sequencer on the consuming end of the lives block's `gameover` output. When lives run out it freezes play, fades the screen through red shades, then shows a blinking GAME OVER panel. It waits for a start press, then issues a timed active-high `game_reset` pulse that re-initialises the lives, bomberman, enemy and bomb blocks. It sits beside the lives block in the top level, and its overlay is muxed over the arena pixel path.

---
 rtl/game_over_ctrl_if.sv | 26 ++
 rtl/game_over_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/game_over_ctrl_if.sv
// Signal bundle between the game top level and the game-over sequencer.
// master = top level / arena side, slave = game_over_ctrl.
interface game_over_ctrl_if;
   logic        gameover;
   logic        start_btn;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        freeze;
   logic        game_reset;
   logic        overlay_on;
   logic [11:0] overlay_rgb;
   logic [1:0]  state_dbg;

   // No valid/ready pairs: gameover and start_btn are levels sampled every clock,
   // x/y are sampled every clock and answered one clock later on overlay_on/overlay_rgb,
   // freeze/game_reset are continuous decodes of the sequencer state.
   modport master (
      output gameover, start_btn, x, y,
      input  freeze, game_reset, overlay_on, overlay_rgb, state_dbg
   );

   modport slave (
      input  gameover, start_btn, x, y,
      output freeze, game_reset, overlay_on, overlay_rgb, state_dbg
   );
endinterface

// File: rtl/game_over_ctrl.sv
// Game-over sequencer: freeze, red fade, blinking GAME OVER panel, wait for
// start, then a timed game_reset pulse before returning to play.
module game_over_ctrl #(
   parameter int FADE_CYCLES    = 100000000,
   parameter int BLINK_CYCLES   = 25000000,
   parameter int RESTART_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   game_over_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      PLAY    = 2'd0,
      DYING   = 2'd1,
      OVER    = 2'd2,
      RESTART = 2'd3
   } state_t;

   localparam logic [27:0] FADE_LAST    = 28'(FADE_CYCLES - 1);
   localparam logic [27:0] BLINK_LAST   = 28'(BLINK_CYCLES - 1);
   localparam logic [27:0] RESTART_LAST = 28'(RESTART_CYCLES - 1);
   localparam logic [27:0] FADE_Q1      = 28'(FADE_CYCLES / 4);
   localparam logic [27:0] FADE_Q2      = 28'((FADE_CYCLES / 4) * 2);
   localparam logic [27:0] FADE_Q3      = 28'((FADE_CYCLES / 4) * 3);

   state_t      state;
   logic [27:0] cnt;
   logic [27:0] blink_cnt;
   logic        blink_ph;
   logic        btn_s1;
   logic        btn_s2;
   logic        btn_prev;
   logic        start_pe;
   logic        overlay_on_q;
   logic [11:0] overlay_rgb_q;
   logic [3:0]  fade_red;
   logic        in_panel;

   assign start_pe = btn_s2 & ~btn_prev;

   // Threshold compares give cnt / (FADE_CYCLES/4) without a divider.
   always_comb begin
      fade_red = 4'h4;
      if (cnt < FADE_Q1)      fade_red = 4'hA;
      else if (cnt < FADE_Q2) fade_red = 4'h8;
      else if (cnt < FADE_Q3) fade_red = 4'h6;
   end

   assign in_panel = (bus.x > 10'd220) && (bus.x < 10'd420) &&
                     (bus.y > 10'd200) && (bus.y < 10'd280);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= PLAY;
         cnt           <= '0;
         blink_cnt     <= '0;
         blink_ph      <= 1'b1;
         btn_s1        <= 1'b0;
         btn_s2        <= 1'b0;
         btn_prev      <= 1'b0;
         overlay_on_q  <= 1'b0;
         overlay_rgb_q <= '0;
      end else begin
         btn_s1   <= bus.start_btn;
         btn_s2   <= btn_s1;
         btn_prev <= btn_s2;

         // Overlay is built from the pre-edge state, giving one clock of pixel latency.
         overlay_on_q  <= 1'b0;
         overlay_rgb_q <= '0;
         if (state == DYING) begin
            overlay_on_q  <= 1'b1;
            overlay_rgb_q <= {fade_red, 8'h00};
         end else if (state == OVER && in_panel) begin
            overlay_on_q  <= 1'b1;
            overlay_rgb_q <= blink_ph ? 12'hFFF : 12'h000;
         end

         case (state)
            PLAY: begin
               if (bus.gameover) begin
                  state <= DYING;
                  cnt   <= '0;
               end
            end
            DYING: begin
               if (cnt == FADE_LAST) begin
                  state     <= OVER;
                  cnt       <= '0;
                  blink_cnt <= '0;
                  blink_ph  <= 1'b1;
               end else begin
                  cnt <= cnt + 28'd1;
               end
            end
            OVER: begin
               if (start_pe) begin
                  state <= RESTART;
                  cnt   <= '0;
               end else if (blink_cnt == BLINK_LAST) begin
                  blink_cnt <= '0;
                  blink_ph  <= ~blink_ph;
               end else begin
                  blink_cnt <= blink_cnt + 28'd1;
               end
            end
            RESTART: begin
               if (cnt == RESTART_LAST) begin
                  state <= PLAY;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 28'd1;
               end
            end
            default: begin
               state <= PLAY;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.freeze      = (state == DYING) || (state == OVER);
   assign bus.game_reset  = (state == RESTART);
   assign bus.overlay_on  = overlay_on_q;
   assign bus.overlay_rgb = overlay_rgb_q;
   assign bus.state_dbg   = state;

endmodule
